// File: rtl/cost_agg_pkg.sv
// Shared constants and types for the SGBM aggregate-cost pipeline stages.
package cost_agg_pkg;

  localparam int DATA_W    = 864;  // 96 disparities x 9 bits
  localparam int IMAGE_COL = 400;
  localparam int IMAGE_ROW = 200;
  localparam int COL_W     = $clog2(IMAGE_COL);
  localparam int ROW_W     = $clog2(IMAGE_ROW);

  // Read-side sequencer of the row reversal buffer
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/cost_line_reverse_row_bank_ram.sv
// row_bank_ram: simple dual-port RAM holding two row banks addressed {bank, col}.
// Synchronous write, registered read output, no reset on the storage.
// The array spans every {bank, col} code so a non-power-of-two row width
// still maps each bank onto its own half.
module row_bank_ram #(
  parameter int DATA_W = 864,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Write port: store the incoming word at its bank/column slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: registered output, updated only when a read is issued
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cost_line_reverse.sv
// cost_line_reverse: ping-pong row buffer that re-emits each completed row
// right to left at full rate. Optional frame flag (`last`) is enabled by
// defining LINE_REV_FRAME_FLAG_EN.
module cost_line_reverse #(
  parameter int DATA_W    = cost_agg_pkg::DATA_W,
  parameter int IMAGE_COL = cost_agg_pkg::IMAGE_COL,
  parameter int IMAGE_ROW = cost_agg_pkg::IMAGE_ROW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid
`ifdef LINE_REV_FRAME_FLAG_EN
  ,
  output logic              last
`endif
);

  import cost_agg_pkg::rd_state_e;
  import cost_agg_pkg::IDLE;
  import cost_agg_pkg::READ;

  localparam int            CW       = (IMAGE_COL > 1) ? $clog2(IMAGE_COL) : 1;
  localparam int            AW       = CW + 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_COL - 1);

  logic [CW-1:0]     wr_col_q, wr_col_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_start_s;
  rd_state_e         state_q, state_d;
  logic [CW-1:0]     rd_col_q, rd_col_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_issue_s;
  logic              rd_col0_s;
  logic              rd_v1_q, rd_v1_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] ram_rd_data_s;

  // Write side: advance column on each accepted beat, swap bank at row end
  always_comb begin
    wr_col_d   = wr_col_q;
    wr_bank_d  = wr_bank_q;
    rd_start_s = 1'b0;
    if (en) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d   = {CW{1'b0}};
        wr_bank_d  = ~wr_bank_q;
        rd_start_s = 1'b1;
      end else begin
        wr_col_d = wr_col_q + CW'(1);
      end
    end else begin
      wr_col_d = wr_col_q;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state plus read column/bank sequencing
  always_comb begin
    state_d   = state_q;
    rd_col_d  = rd_col_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      IDLE: begin
        if (rd_start_s) begin
          state_d   = READ;
          rd_col_d  = LAST_COL;
          rd_bank_d = wr_bank_q;   // bank completing on this edge
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (rd_col_q == {CW{1'b0}}) begin
          if (rd_start_s) begin
            // next row finished exactly as this one drains: chain with no bubble
            state_d   = READ;
            rd_col_d  = LAST_COL;
            rd_bank_d = wr_bank_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rd_col_d = rd_col_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read FSM outputs: a RAM read is issued every cycle spent in READ
  always_comb begin
    rd_issue_s = (state_q == READ);
    rd_col0_s  = (state_q == READ) && (rd_col_q == {CW{1'b0}});
  end

  // Output pipeline: RAM register stage then the output register
  always_comb begin
    rd_v1_d    = rd_issue_s;
    valid_d    = rd_v1_q;
    data_out_d = rd_v1_q ? ram_rd_data_s : data_out_q;
  end

  // Counters, read pointers and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_col_q   <= {CW{1'b0}};
      wr_bank_q  <= 1'b0;
      rd_col_q   <= {CW{1'b0}};
      rd_bank_q  <= 1'b0;
      rd_v1_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= {DATA_W{1'b0}};
    end else begin
      wr_col_q   <= wr_col_d;
      wr_bank_q  <= wr_bank_d;
      rd_col_q   <= rd_col_d;
      rd_bank_q  <= rd_bank_d;
      rd_v1_q    <= rd_v1_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;

  row_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .we    (en),
    .waddr ({wr_bank_q, wr_col_q}),
    .wdata (data_in),
    .re    (rd_issue_s),
    .raddr ({rd_bank_q, rd_col_q}),
    .rdata (ram_rd_data_s)
  );

`ifdef LINE_REV_FRAME_FLAG_EN
  localparam int            RW       = (IMAGE_ROW > 1) ? $clog2(IMAGE_ROW) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_ROW - 1);

  logic [RW-1:0] row_q, row_d;
  logic          last_v1_q, last_v1_d;
  logic          last_q, last_d;

  // Frame row counter: advances as each row's column-0 read is issued
  always_comb begin
    row_d     = row_q;
    last_v1_d = 1'b0;
    if (rd_col0_s) begin
      last_v1_d = (row_q == LAST_ROW);
      row_d     = (row_q == LAST_ROW) ? {RW{1'b0}} : row_q + RW'(1);
    end else begin
      row_d = row_q;
    end
    last_d = last_v1_q;
  end

  // Frame flag registers, aligned with the valid pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= {RW{1'b0}};
      last_v1_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      last_v1_q <= last_v1_d;
      last_q    <= last_d;
    end
  end

  assign last = last_q;
`endif

endmodule
